spi_fsm: RTL
============

SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 SHALL have parameter width, default 8, bits per SPI field (address+R/W byte, data byte).
REQ-002 SHALL have port clk, input, 1, FPGA clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port cs, input, 1, conditioned chip select, active low.
REQ-005 SHALL have port sclk_rise, input, 1, one-clk pulse per conditioned SCLK rising edge.
REQ-006 SHALL have port sclk_fall, input, 1, one-clk pulse per conditioned SCLK falling edge.
REQ-007 SHALL have port sr_lsb, input, 1, shift register parallel-out bit 0 (R/W flag; 1 = read).
REQ-008 SHALL have port addr_we, output, 1, address latch write enable.
REQ-009 SHALL have port dm_we, output, 1, data memory write enable.
REQ-010 SHALL have port sr_we, output, 1, shift register parallel-load enable (drives pload).
REQ-011 SHALL have port miso_buff_en, output, 1, MISO tri-state buffer enable.

Function
REQ-012 SHALL implement states IDLE, ADDR_RECV, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_STORE, DONE.
REQ-013 SHALL have Moore outputs decoded from registered state only; no input-to-output combinational path.
REQ-014 SHALL keep a bit counter of $clog2(width)+1 bits, cleared on every state entry.
REQ-015 IDLE: on cs==0 SHALL go to ADDR_RECV next cycle; all outputs 0.
REQ-016 ADDR_RECV: SHALL count sclk_rise; on the width-th pulse SHALL go to GOT_ADDR.
REQ-017 GOT_ADDR: SHALL last exactly one cycle with addr_we=1; SHALL sample sr_lsb there; 1 -> READ_LOAD, 0 -> WRITE_RECV.
REQ-018 READ_LOAD: SHALL last exactly one cycle with sr_we=1, then go to READ_SEND.
REQ-019 READ_SEND: miso_buff_en=1; SHALL count sclk_fall; on the width-th pulse SHALL go to DONE.
REQ-020 WRITE_RECV: SHALL count sclk_rise; on the width-th pulse SHALL go to WRITE_STORE.
REQ-021 WRITE_STORE: SHALL last exactly one cycle with dm_we=1, then go to DONE.
REQ-022 DONE: all outputs 0; SHALL ignore SCLK pulses; SHALL go to IDLE when cs==1.
REQ-023 cs==1 in any non-IDLE state SHALL abort to IDLE next cycle; abort takes priority over counting and branching.
REQ-024 SHALL not assert dm_we on an aborted write.
REQ-025 sclk_rise and sclk_fall asserted in the same cycle SHALL each count only in the state that uses it.
REQ-026 SCLK pulses in IDLE SHALL be ignored.
REQ-027 At most one of addr_we, dm_we and sr_we SHALL be high in any cycle.

Reset
REQ-028 reset==1 at a clk edge SHALL force IDLE and clear the counter, overriding all inputs, including mid-transaction.
REQ-029 During and after reset, outputs SHALL be 0 until the next cs==0 is sampled.

Structure
REQ-030 SHALL take state encodings and the default width from shared package spi_pkg.
REQ-031 SHALL use one sub-module, spi_bitcounter (clear, increment, terminal-count flag at width).
REQ-032 SHALL be sized at 120-250 lines of RTL, with no memories or multipliers.

Verification
REQ-033 Write: cs=0; 8 rises, bits 1010101_0; 8 rises, data 0x5A -> addr_we pulse once, dm_we pulse once, miso_buff_en never 1.
REQ-034 Read: cs=0; 8 rises, bits 0000011_1 -> addr_we pulse, then sr_we pulse next cycle, then miso_buff_en=1 for exactly 8 sclk_fall, then 0.
REQ-035 Abort: cs=1 after 5 data rises in WRITE_RECV -> IDLE next cycle; dm_we never asserted.
REQ-036 Reset mid READ_SEND (3 falls done) -> miso_buff_en 0 next cycle; a new transaction decodes correctly.
REQ-037 Back-to-back: DONE, cs 0->1->0 within 2 cycles -> second write completes with one dm_we pulse.
REQ-038 Noise: 20 SCLK pulses in IDLE with cs=1 -> outputs stay 0, state stays IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave control FSM: state encoding,
// default field width and the per-state control decode.
package spi_pkg;

  localparam int DefaultWidth = 8;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ADDR_RECV   = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SEND   = 3'd4,
    WRITE_RECV  = 3'd5,
    WRITE_STORE = 3'd6,
    DONE        = 3'd7
  } state_e;

  typedef struct packed {
    logic addrWe;
    logic dmWe;
    logic srWe;
    logic misoBuffEn;
  } ctrl_t;

  // Each strobe belongs to exactly one state, so at most one write enable is ever high.
  function automatic ctrl_t decodeOutputs(input state_e state);
    ctrl_t ctrl;
    ctrl = '0;
    case (state)
      GOT_ADDR:    ctrl.addrWe     = 1'b1;
      READ_LOAD:   ctrl.srWe       = 1'b1;
      READ_SEND:   ctrl.misoBuffEn = 1'b1;
      WRITE_STORE: ctrl.dmWe       = 1'b1;
      default:     ctrl            = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/spi_bitcounter.sv
// SCLK edge counter for one SPI field; tc_o marks the increment that
// completes the field so the FSM can move on with that same pulse.
module spi_bitcounter
  import spi_pkg::*;
#(
  parameter int width = DefaultWidth
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int CntW = $clog2(width) + 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(width - 1);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  // Clear wins over increment so a pulse landing on a state change is not carried over.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = inc_i && (count_q == LastIdx);

endmodule

// File: rtl/spi_fsm.sv
// SPI slave transaction controller: address byte with R/W flag, then either
// a data byte written to memory or a data byte shifted out on MISO.
module spi_fsm
  import spi_pkg::*;
#(
  parameter int width = DefaultWidth
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic sr_lsb,
  output logic addr_we,
  output logic dm_we,
  output logic sr_we,
  output logic miso_buff_en
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_q;

  logic cntInc;
  logic cntClear;
  logic cntTc;

  // Slave samples on SCLK rise while receiving and drives on SCLK fall while sending.
  always_comb begin
    cntInc = 1'b0;
    case (state_q)
      ADDR_RECV, WRITE_RECV: cntInc = sclk_rise;
      READ_SEND:             cntInc = sclk_fall;
      default:               cntInc = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && cs) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:        if (!cs) state_d = ADDR_RECV;
        ADDR_RECV:   if (cntTc) state_d = GOT_ADDR;
        GOT_ADDR:    state_d = sr_lsb ? READ_LOAD : WRITE_RECV;
        READ_LOAD:   state_d = READ_SEND;
        READ_SEND:   if (cntTc) state_d = DONE;
        WRITE_RECV:  if (cntTc) state_d = WRITE_STORE;
        WRITE_STORE: state_d = DONE;
        DONE:        state_d = DONE;
        default:     state_d = IDLE;
      endcase
    end
  end

  assign cntClear = (state_d != state_q);

  // Outputs are registered from the next state, so they always match the decode of state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decodeOutputs(state_d);
    end
  end

  spi_bitcounter #(
    .width(width)
  ) u_bitcounter (
    .clk_i  (clk),
    .reset_i(reset),
    .clear_i(cntClear),
    .inc_i  (cntInc),
    .tc_o   (cntTc)
  );

  assign addr_we      = ctrl_q.addrWe;
  assign dm_we        = ctrl_q.dmWe;
  assign sr_we        = ctrl_q.srWe;
  assign miso_buff_en = ctrl_q.misoBuffEn;

endmodule
